// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Programmable raster timing generator. It produces HSync/VSync/HBlank/VBlank
//   and the pixel/line counters. Geometry comes from an active register bank.
//   A runtime write lands in a shadow bank and is copied into the active bank
//   only when the raster wraps to (0,0), so no frame is ever torn.
//
// Ports
//   clk_vid      video clock
//   reset        asynchronous, active-high
//   ce_pix       pixel enable; timing advances only on enabled edges
//   cfg_wr       one-clk strobe; latches cfg_h/cfg_v into the shadow bank
//   cfg_h/cfg_v  {active, fp, sync, bp} horizontal / vertical geometry
//   cfg_pending  shadow geometry waiting for the next frame boundary
//   cfg_err      one-clk pulse after a rejected cfg_wr
//   hcount       pixel index in line, 0..HT-1
//   vcount       line index in frame, 0..VT-1
//   HSync/VSync/HBlank/VBlank  registered timing outputs for hcount/vcount
//   frame_start  one-clk pulse after the enabled edge that loaded (0,0)
module video_timing_gen #(
  parameter int CW       = 12,
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 8,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 15,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic            clk_vid,
  input  logic            reset,
  input  logic            ce_pix,
  input  logic            cfg_wr,
  input  logic [4*CW-1:0] cfg_h,
  input  logic [4*CW-1:0] cfg_v,
  output logic            cfg_pending,
  output logic            cfg_err,
  output logic [CW-1:0]   hcount,
  output logic [CW-1:0]   vcount,
  output logic            HSync,
  output logic            VSync,
  output logic            HBlank,
  output logic            VBlank,
  output logic            frame_start
);

  localparam int TW = CW + 2;
  localparam logic [TW-1:0] T_MAX = {2'b01, {CW{1'b0}}};

  typedef struct packed {
    logic [CW-1:0] act;
    logic [CW-1:0] fp;
    logic [CW-1:0] sync;
    logic [CW-1:0] bp;
  } geom_t;

  localparam geom_t H_DEF = '{act: CW'(H_ACTIVE), fp: CW'(H_FP), sync: CW'(H_SYNC), bp: CW'(H_BP)};
  localparam geom_t V_DEF = '{act: CW'(V_ACTIVE), fp: CW'(V_FP), sync: CW'(V_SYNC), bp: CW'(V_BP)};

  function automatic logic [TW-1:0] total(input geom_t g);
    return TW'(g.act) + TW'(g.fp) + TW'(g.sync) + TW'(g.bp);
  endfunction

  function automatic logic valid(input geom_t g);
    return (g.act != '0) && (g.sync != '0) && (total(g) <= T_MAX);
  endfunction

  function automatic logic in_sync(input logic [CW-1:0] pos, input logic [CW-1:0] act,
                                   input logic [CW-1:0] fp, input logic [CW-1:0] sync);
    logic [TW-1:0] s0;
    s0 = TW'(act) + TW'(fp);
    return (TW'(pos) >= s0) && (TW'(pos) < s0 + TW'(sync));
  endfunction

  logic [CW-1:0] hcount_q, hcount_d, vcount_q, vcount_d;
  logic          hsync_q, hsync_d, vsync_q, vsync_d;
  logic          hblank_q, hblank_d, vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;
  logic          cfg_pending_q, cfg_pending_d;
  logic          cfg_err_q, cfg_err_d;
  geom_t         act_h_q, act_h_d, act_v_q, act_v_d;
  geom_t         shd_h_q, shd_h_d, shd_v_q, shd_v_d;

  logic [TW-1:0] ht, vt;
  logic          h_last, v_last, wrap, apply;

  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    hblank_d      = hblank_q;
    vblank_d      = vblank_q;
    frame_start_d = 1'b0;
    cfg_pending_d = cfg_pending_q;
    cfg_err_d     = 1'b0;
    act_h_d       = act_h_q;
    act_v_d       = act_v_q;
    shd_h_d       = shd_h_q;
    shd_v_d       = shd_v_q;

    ht     = total(act_h_q);
    vt     = total(act_v_q);
    h_last = (TW'(hcount_q) == ht - TW'(1));
    v_last = (TW'(vcount_q) == vt - TW'(1));
    wrap   = h_last && v_last;
    apply  = ce_pix && wrap && cfg_pending_q;

    if (ce_pix) begin
      hcount_d = h_last ? '0 : hcount_q + CW'(1);
      if (h_last) begin
        vcount_d = v_last ? '0 : vcount_q + CW'(1);
      end
      frame_start_d = wrap;
      // The bank swap happens before decode so (0,0) is already decoded
      // with the new geometry.
      if (apply) begin
        act_h_d       = shd_h_q;
        act_v_d       = shd_v_q;
        cfg_pending_d = 1'b0;
      end
      hblank_d = (hcount_d >= act_h_d.act);
      vblank_d = (vcount_d >= act_v_d.act);
      hsync_d  = in_sync(hcount_d, act_h_d.act, act_h_d.fp, act_h_d.sync) ? HS_POL : ~HS_POL;
      vsync_d  = in_sync(vcount_d, act_v_d.act, act_v_d.fp, act_v_d.sync) ? VS_POL : ~VS_POL;
    end

    // A write that coincides with an apply lands after the old shadow was
    // consumed, so it stays pending for the following frame.
    if (cfg_wr) begin
      if (valid(geom_t'(cfg_h)) && valid(geom_t'(cfg_v))) begin
        shd_h_d       = geom_t'(cfg_h);
        shd_v_d       = geom_t'(cfg_v);
        cfg_pending_d = 1'b1;
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      cfg_pending_q <= 1'b0;
      cfg_err_q     <= 1'b0;
      act_h_q       <= H_DEF;
      act_v_q       <= V_DEF;
      shd_h_q       <= H_DEF;
      shd_v_q       <= V_DEF;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_err_q     <= cfg_err_d;
      act_h_q       <= act_h_d;
      act_v_q       <= act_v_d;
      shd_h_q       <= shd_h_d;
      shd_v_q       <= shd_v_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign frame_start = frame_start_q;
  assign cfg_pending = cfg_pending_q;
  assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen
//   Directed bench for video_timing_gen with a small 8x6 raster
//   (H 4/1/2/1, V 3/1/1/1, active-low syncs). A raster model tracks the
//   expected position, banks and pending flag; each scenario task checks the
//   outputs it exercises.
module tb_video_timing_gen;

  logic        clk_vid = 1'b0;
  logic        reset;
  logic        ce_pix;
  logic        cfg_wr;
  logic [47:0] cfg_h, cfg_v;
  logic        cfg_pending, cfg_err;
  logic [11:0] hcount, vcount;
  logic        HSync, VSync, HBlank, VBlank, frame_start;

  localparam logic [47:0] H_DEF = {12'd4, 12'd1, 12'd2, 12'd1};
  localparam logic [47:0] V_DEF = {12'd3, 12'd1, 12'd1, 12'd1};

  int npass = 0;
  int nchk  = 0;
  int clk_n = 0;

  // raster model
  int          eh, ev;
  logic [47:0] eah, eav, esh, esv;
  bit          epend, efs, eerr;

  video_timing_gen #(
    .CW(12), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix), .cfg_wr(cfg_wr),
    .cfg_h(cfg_h), .cfg_v(cfg_v), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
    .hcount(hcount), .vcount(vcount), .HSync(HSync), .VSync(VSync),
    .HBlank(HBlank), .VBlank(VBlank), .frame_start(frame_start)
  );

  always #5 clk_vid = ~clk_vid;
  always @(posedge clk_vid) clk_n++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int g_act(input logic [47:0] g); return int'(g[47:36]); endfunction
  function automatic int g_fp(input logic [47:0] g);  return int'(g[35:24]); endfunction
  function automatic int g_sy(input logic [47:0] g);  return int'(g[23:12]); endfunction
  function automatic int g_tot(input logic [47:0] g);
    return int'(g[47:36]) + int'(g[35:24]) + int'(g[23:12]) + int'(g[11:0]);
  endfunction
  function automatic bit g_ok(input logic [47:0] g);
    return g_act(g) != 0 && g_sy(g) != 0 && g_tot(g) <= 4096;
  endfunction

  function automatic bit exp_hb(); return eh >= g_act(eah); endfunction
  function automatic bit exp_vb(); return ev >= g_act(eav); endfunction
  function automatic bit exp_hs();
    int s0;
    s0 = g_act(eah) + g_fp(eah);
    return (eh >= s0 && eh < s0 + g_sy(eah)) ? 1'b0 : 1'b1;
  endfunction
  function automatic bit exp_vs();
    int s0;
    s0 = g_act(eav) + g_fp(eav);
    return (ev >= s0 && ev < s0 + g_sy(eav)) ? 1'b0 : 1'b1;
  endfunction

  task automatic model_reset();
    eh = 0; ev = 0;
    eah = H_DEF; eav = V_DEF; esh = H_DEF; esv = V_DEF;
    epend = 1'b0; efs = 1'b0; eerr = 1'b0;
  endtask

  // Drive one clock of stimulus, then advance the model to match.
  task automatic step(input bit ce, input bit wr, input logic [47:0] h, input logic [47:0] v);
    int ht, vt;
    ce_pix = ce; cfg_wr = wr; cfg_h = h; cfg_v = v;
    @(posedge clk_vid);
    #1;
    cfg_wr = 1'b0;
    efs = 1'b0; eerr = 1'b0;
    ht = g_tot(eah); vt = g_tot(eav);
    if (ce) begin
      if (eh == ht - 1) begin
        eh = 0;
        if (ev == vt - 1) begin
          ev = 0;
          efs = 1'b1;
          if (epend) begin eah = esh; eav = esv; epend = 1'b0; end
        end else ev++;
      end else eh++;
    end
    if (wr) begin
      if (g_ok(h) && g_ok(v)) begin esh = h; esv = v; epend = 1'b1; end
      else eerr = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ce_pix = 1'b0; cfg_wr = 1'b0; cfg_h = '0; cfg_v = '0;
    model_reset();
    repeat (2) @(posedge clk_vid);
    #1;
    nchk++; if (hcount !== 12'd0) $display("FAIL reset_hcount got=%0d want=0", hcount); else npass++;
    nchk++; if (vcount !== 12'd0) $display("FAIL reset_vcount got=%0d want=0", vcount); else npass++;
    nchk++; if (HBlank !== 1'b0) $display("FAIL reset_hblank got=%b want=0", HBlank); else npass++;
    nchk++; if (VBlank !== 1'b0) $display("FAIL reset_vblank got=%b want=0", VBlank); else npass++;
    nchk++; if (HSync !== 1'b1) $display("FAIL reset_hsync got=%b want=1", HSync); else npass++;
    nchk++; if (VSync !== 1'b1) $display("FAIL reset_vsync got=%b want=1", VSync); else npass++;
    nchk++; if (frame_start !== 1'b0) $display("FAIL reset_fs got=%b want=0", frame_start); else npass++;
    nchk++; if (cfg_pending !== 1'b0) $display("FAIL reset_pending got=%b want=0", cfg_pending); else npass++;
    nchk++; if (cfg_err !== 1'b0) $display("FAIL reset_err got=%b want=0", cfg_err); else npass++;
    reset = 1'b0;
  endtask

  // Default 8x6 raster with ce every clock; expectations are hand constants.
  task automatic test_raster();
    int fs_last = -1;
    for (int k = 0; k < 96; k++) begin
      step(1'b1, 1'b0, '0, '0);
      nchk++; if (hcount !== 12'(eh)) $display("FAIL raster_hcount k=%0d got=%0d want=%0d", k, hcount, eh); else npass++;
      nchk++; if (vcount !== 12'(ev)) $display("FAIL raster_vcount k=%0d got=%0d want=%0d", k, vcount, ev); else npass++;
      nchk++; if (HBlank !== (eh >= 4)) $display("FAIL raster_hblank h=%0d got=%b", eh, HBlank); else npass++;
      nchk++; if (HSync !== !(eh == 5 || eh == 6)) $display("FAIL raster_hsync h=%0d got=%b", eh, HSync); else npass++;
      nchk++; if (VBlank !== (ev >= 3)) $display("FAIL raster_vblank v=%0d got=%b", ev, VBlank); else npass++;
      nchk++; if (VSync !== (ev != 4)) $display("FAIL raster_vsync v=%0d got=%b", ev, VSync); else npass++;
      nchk++; if (frame_start !== efs) $display("FAIL raster_fs k=%0d got=%b want=%b", k, frame_start, efs); else npass++;
      if (frame_start === 1'b1) begin
        if (fs_last >= 0) begin
          nchk++; if (clk_n - fs_last !== 48) $display("FAIL raster_fs_period got=%0d want=48", clk_n - fs_last); else npass++;
        end
        fs_last = clk_n;
      end
    end
  endtask

  task automatic test_ce_spacing();
    int fs_last = -1;
    int ln_last = -1;
    logic [11:0] prev_h;
    prev_h = hcount;
    for (int k = 0; k < 288; k++) begin
      step((k % 3) == 0, 1'b0, '0, '0);
      nchk++; if (hcount !== 12'(eh)) $display("FAIL ce_hcount k=%0d got=%0d want=%0d", k, hcount, eh); else npass++;
      nchk++; if (vcount !== 12'(ev)) $display("FAIL ce_vcount k=%0d got=%0d want=%0d", k, vcount, ev); else npass++;
      nchk++; if (HBlank !== exp_hb()) $display("FAIL ce_hblank k=%0d got=%b want=%b", k, HBlank, exp_hb()); else npass++;
      nchk++; if (HSync !== exp_hs()) $display("FAIL ce_hsync k=%0d got=%b want=%b", k, HSync, exp_hs()); else npass++;
      nchk++; if (VBlank !== exp_vb()) $display("FAIL ce_vblank k=%0d got=%b want=%b", k, VBlank, exp_vb()); else npass++;
      nchk++; if (frame_start !== efs) $display("FAIL ce_fs k=%0d got=%b want=%b", k, frame_start, efs); else npass++;
      if (frame_start === 1'b1) begin
        if (fs_last >= 0) begin
          nchk++; if (clk_n - fs_last !== 144) $display("FAIL ce_fs_period got=%0d want=144", clk_n - fs_last); else npass++;
        end
        fs_last = clk_n;
      end
      if (hcount === 12'd0 && prev_h !== 12'd0) begin
        if (ln_last >= 0) begin
          nchk++; if (clk_n - ln_last !== 24) $display("FAIL ce_line_period got=%0d want=24", clk_n - ln_last); else npass++;
        end
        ln_last = clk_n;
      end
      prev_h = hcount;
    end
  endtask

  task automatic test_cfg_change();
    int nfs = 0;
    int hmax = 0;
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, {12'd8, 12'd2, 12'd2, 12'd2}, V_DEF);
    nchk++; if (cfg_pending !== 1'b1) $display("FAIL chg_pending_rise got=%b want=1", cfg_pending); else npass++;
    nchk++; if (cfg_err !== 1'b0) $display("FAIL chg_err got=%b want=0", cfg_err); else npass++;
    for (int k = 0; k < 300 && nfs < 2; k++) begin
      step(1'b1, 1'b0, '0, '0);
      nchk++; if (hcount !== 12'(eh)) $display("FAIL chg_hcount k=%0d got=%0d want=%0d", k, hcount, eh); else npass++;
      nchk++; if (vcount !== 12'(ev)) $display("FAIL chg_vcount k=%0d got=%0d want=%0d", k, vcount, ev); else npass++;
      nchk++; if (HBlank !== exp_hb()) $display("FAIL chg_hblank k=%0d got=%b want=%b", k, HBlank, exp_hb()); else npass++;
      nchk++; if (HSync !== exp_hs()) $display("FAIL chg_hsync k=%0d got=%b want=%b", k, HSync, exp_hs()); else npass++;
      nchk++; if (cfg_pending !== epend) $display("FAIL chg_pending k=%0d got=%b want=%b", k, cfg_pending, epend); else npass++;
      nchk++; if (frame_start !== efs) $display("FAIL chg_fs k=%0d got=%b want=%b", k, frame_start, efs); else npass++;
      if (efs) nfs++;
      if (nfs == 1 && int'(hcount) > hmax) hmax = int'(hcount);
    end
    nchk++; if (nfs !== 2) $display("FAIL chg_frames got=%0d want=2", nfs); else npass++;
    nchk++; if (hmax !== 13) $display("FAIL chg_new_line_max got=%0d want=13", hmax); else npass++;
    nchk++; if (cfg_pending !== 1'b0) $display("FAIL chg_pending_clear got=%b want=0", cfg_pending); else npass++;
  endtask

  task automatic test_cfg_reject();
    step(1'b1, 1'b1, {12'd6, 12'd1, 12'd0, 12'd1}, V_DEF);
    nchk++; if (cfg_err !== 1'b1) $display("FAIL rej_hsync0_err got=%b want=1", cfg_err); else npass++;
    nchk++; if (cfg_pending !== 1'b0) $display("FAIL rej_hsync0_pending got=%b want=0", cfg_pending); else npass++;
    step(1'b1, 1'b0, '0, '0);
    nchk++; if (cfg_err !== 1'b0) $display("FAIL rej_err_width got=%b want=0", cfg_err); else npass++;
    step(1'b1, 1'b1, {12'd4000, 12'd50, 12'd40, 12'd7}, V_DEF);
    nchk++; if (cfg_err !== 1'b1) $display("FAIL rej_ht4097_err got=%b want=1", cfg_err); else npass++;
    nchk++; if (cfg_pending !== 1'b0) $display("FAIL rej_ht4097_pending got=%b want=0", cfg_pending); else npass++;
    step(1'b1, 1'b1, {12'd8, 12'd2, 12'd2, 12'd2}, {12'd3, 12'd1, 12'd0, 12'd1});
    nchk++; if (cfg_err !== 1'b1) $display("FAIL rej_vsync0_err got=%b want=1", cfg_err); else npass++;
    for (int k = 0; k < 84; k++) begin
      step(1'b1, 1'b0, '0, '0);
      nchk++; if (hcount !== 12'(eh)) $display("FAIL rej_hcount k=%0d got=%0d want=%0d", k, hcount, eh); else npass++;
      nchk++; if (vcount !== 12'(ev)) $display("FAIL rej_vcount k=%0d got=%0d want=%0d", k, vcount, ev); else npass++;
      nchk++; if (HBlank !== exp_hb()) $display("FAIL rej_hblank k=%0d got=%b want=%b", k, HBlank, exp_hb()); else npass++;
      nchk++; if (HSync !== exp_hs()) $display("FAIL rej_hsync k=%0d got=%b want=%b", k, HSync, exp_hs()); else npass++;
      nchk++; if (cfg_pending !== epend) $display("FAIL rej_pending k=%0d got=%b want=%b", k, cfg_pending, epend); else npass++;
      nchk++; if (cfg_err !== eerr) $display("FAIL rej_err k=%0d got=%b want=%b", k, cfg_err, eerr); else npass++;
    end
  endtask

  // HT=4096 boundary, zero porches, write with ce low, and write on the apply edge.
  task automatic test_boundary_overlap();
    int nfs = 0;
    int hmax = 0;
    int guard = 0;
    step(1'b1, 1'b1, {12'd4000, 12'd50, 12'd40, 12'd6}, V_DEF);
    nchk++; if (cfg_err !== 1'b0) $display("FAIL bnd_ht4096_err got=%b want=0", cfg_err); else npass++;
    nchk++; if (cfg_pending !== 1'b1) $display("FAIL bnd_ht4096_pending got=%b want=1", cfg_pending); else npass++;
    step(1'b0, 1'b1, {12'd8, 12'd0, 12'd2, 12'd0}, V_DEF);
    nchk++; if (cfg_err !== 1'b0) $display("FAIL bnd_zero_porch_err got=%b want=0", cfg_err); else npass++;
    nchk++; if (hcount !== 12'(eh)) $display("FAIL bnd_ce_low_hold got=%0d want=%0d", hcount, eh); else npass++;
    while (!(eh == g_tot(eah) - 1 && ev == g_tot(eav) - 1) && guard < 200) begin
      step(1'b1, 1'b0, '0, '0);
      guard++;
    end
    nchk++; if (guard >= 200) $display("FAIL bnd_reach_frame_end got=%0d want<200", guard); else npass++;
    step(1'b1, 1'b1, {12'd6, 12'd1, 12'd1, 12'd1}, V_DEF);
    nchk++; if (frame_start !== 1'b1) $display("FAIL ovl_fs got=%b want=1", frame_start); else npass++;
    nchk++; if (hcount !== 12'd0) $display("FAIL ovl_hcount got=%0d want=0", hcount); else npass++;
    nchk++; if (cfg_pending !== 1'b1) $display("FAIL ovl_pending got=%b want=1", cfg_pending); else npass++;
    for (int k = 0; k < 200 && nfs < 2; k++) begin
      step(1'b1, 1'b0, '0, '0);
      nchk++; if (hcount !== 12'(eh)) $display("FAIL ovl_hcount k=%0d got=%0d want=%0d", k, hcount, eh); else npass++;
      nchk++; if (HBlank !== exp_hb()) $display("FAIL ovl_hblank k=%0d got=%b want=%b", k, HBlank, exp_hb()); else npass++;
      nchk++; if (HSync !== exp_hs()) $display("FAIL ovl_hsync k=%0d got=%b want=%b", k, HSync, exp_hs()); else npass++;
      nchk++; if (cfg_pending !== epend) $display("FAIL ovl_pending k=%0d got=%b want=%b", k, cfg_pending, epend); else npass++;
      nchk++; if (frame_start !== efs) $display("FAIL ovl_fs k=%0d got=%b want=%b", k, frame_start, efs); else npass++;
      if (efs) nfs++;
      if (nfs == 0 && int'(hcount) > hmax) hmax = int'(hcount);
    end
    nchk++; if (nfs !== 2) $display("FAIL ovl_frames got=%0d want=2", nfs); else npass++;
    nchk++; if (hmax !== 9) $display("FAIL ovl_zero_porch_line_max got=%0d want=9", hmax); else npass++;
  endtask

  task automatic test_reset_midline();
    int guard = 0;
    step(1'b1, 1'b1, {12'd8, 12'd2, 12'd2, 12'd2}, V_DEF);
    while (!(eh == 5 && ev == 4) && guard < 100) begin
      step(1'b1, 1'b0, '0, '0);
      guard++;
    end
    nchk++; if (hcount !== 12'd5 || vcount !== 12'd4) $display("FAIL mid_position got=%0d,%0d want=5,4", hcount, vcount); else npass++;
    nchk++; if (VBlank !== 1'b1) $display("FAIL mid_vblank_pre got=%b want=1", VBlank); else npass++;
    #3 reset = 1'b1;
    #1;
    nchk++; if (hcount !== 12'd0) $display("FAIL arst_hcount got=%0d want=0", hcount); else npass++;
    nchk++; if (vcount !== 12'd0) $display("FAIL arst_vcount got=%0d want=0", vcount); else npass++;
    nchk++; if (HBlank !== 1'b0) $display("FAIL arst_hblank got=%b want=0", HBlank); else npass++;
    nchk++; if (VBlank !== 1'b0) $display("FAIL arst_vblank got=%b want=0", VBlank); else npass++;
    nchk++; if (HSync !== 1'b1) $display("FAIL arst_hsync got=%b want=1", HSync); else npass++;
    nchk++; if (VSync !== 1'b1) $display("FAIL arst_vsync got=%b want=1", VSync); else npass++;
    nchk++; if (frame_start !== 1'b0) $display("FAIL arst_fs got=%b want=0", frame_start); else npass++;
    nchk++; if (cfg_pending !== 1'b0) $display("FAIL arst_pending got=%b want=0", cfg_pending); else npass++;
    nchk++; if (cfg_err !== 1'b0) $display("FAIL arst_err got=%b want=0", cfg_err); else npass++;
    #1 reset = 1'b0;
    model_reset();
    for (int k = 0; k < 48; k++) begin
      step(1'b1, 1'b0, '0, '0);
      nchk++; if (hcount !== 12'(eh)) $display("FAIL post_hcount k=%0d got=%0d want=%0d", k, hcount, eh); else npass++;
      nchk++; if (HBlank !== (eh >= 4)) $display("FAIL post_hblank h=%0d got=%b", eh, HBlank); else npass++;
      nchk++; if (HSync !== !(eh == 5 || eh == 6)) $display("FAIL post_hsync h=%0d got=%b", eh, HSync); else npass++;
      nchk++; if (cfg_pending !== 1'b0) $display("FAIL post_pending k=%0d got=%b want=0", k, cfg_pending); else npass++;
      nchk++; if (frame_start !== efs) $display("FAIL post_fs k=%0d got=%b want=%b", k, frame_start, efs); else npass++;
    end
  endtask

  initial begin
    test_reset();
    test_raster();
    test_ce_spacing();
    test_cfg_change();
    test_cfg_reject();
    test_boundary_overlap();
    test_reset_midline();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
